qupls_rb_encode_seq: RTL and testbench
======================================

QUPLS_RB_ENCODE_SEQ -- requirements
Module: qupls_rb_encode_seq

Interface
REQ-001 SHALL have parameter MAXCNT, default 8, maximum registers emitted per request (range 1..64).
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port flush_i  input  1  abort current sequence.
REQ-005 SHALL have port req_valid_i  input  1  request present.
REQ-006 SHALL have port req_ready_o  output  1  request accepted when valid&ready.
REQ-007 SHALL have port req_instr_i  input  instruction_t  template instruction.
REQ-008 SHALL have port req_rb_i  input  aregno_t (7)  first Rb register.
REQ-009 SHALL have port req_cnt_i  input  $clog2(MAXCNT+1)  registers to emit.
REQ-010 SHALL have port req_down_i  input  1  0 = increment Rb, 1 = decrement.
REQ-011 SHALL have port out_valid_o  output  1  encoded instruction present.
REQ-012 SHALL have port out_ready_i  input  1  consumer accepts when valid&ready.
REQ-013 SHALL have port out_instr_o  output  instruction_t  template with Rb field [24:19] replaced.
REQ-014 SHALL have port out_regx_o  output  1  bit 6 of emitted Rb (register-extension bit).
REQ-015 SHALL have port out_last_o  output  1  final instruction of sequence.
REQ-016 SHALL have port done_o  output  1  one-cycle pulse after last handshake.

Function
REQ-017 SHALL implement states IDLE, EMIT, DONE.
REQ-018 IDLE: req_ready_o=1; on handshake with req_cnt_i>0 latch template, Rb, count, direction, go EMIT.
REQ-019 IDLE handshake with req_cnt_i=0 SHALL go DONE with no output emitted.
REQ-020 req_cnt_i>MAXCNT SHALL be clamped to MAXCNT.
REQ-021 EMIT: out_valid_o=1 from the cycle after acceptance (1-cycle latency); out_instr_o[24:19]=cur_rb[5:0], all other bits equal template; out_regx_o=cur_rb[6].
REQ-022 EMIT outputs SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-023 On output handshake cur_rb SHALL step +1 or -1 modulo 128 (127->0, 0->127), remaining count decrements.
REQ-024 out_last_o=1 when remaining count=1; its handshake SHALL move to DONE.
REQ-025 DONE: done_o=1 for exactly one cycle, then IDLE; req_ready_o=0 in EMIT and DONE.
REQ-026 flush_i SHALL take priority over all handshakes: next state IDLE, out_valid_o=0 next cycle, no done_o pulse.
REQ-027 flush_i coincident with a request handshake SHALL discard the request.

Reset
REQ-028 rst_i SHALL force IDLE; req_ready_o=0 during reset cycle, then 1.
REQ-029 Reset values: out_valid_o=0, out_last_o=0, done_o=0, out_regx_o=0, out_instr_o=0, count=0.
REQ-030 Reset mid-sequence SHALL abandon it with no further output and no done_o.

Configuration
REQ-031 Macro QUPLS_RB_SEQ_SKIP_R0_EN: when defined, a cur_rb value of 0 (regx=0, field=0) SHALL be skipped with no output and without consuming count, costing one bubble cycle.
REQ-032 Without QUPLS_RB_SEQ_SKIP_R0_EN, register 0 SHALL be emitted like any other.

Structure
REQ-033 instruction_t, aregno_t and localparams RB_LSB=19, RB_MSB=24 SHALL live in QuplsPkg.
REQ-034 Field insertion SHALL be a combinational sub-module qupls_encode_rb_field (instr, Rb in; instr, regx out), exact inverse of the Rb field decode.

Verification
REQ-035 req_rb=5, cnt=3, up, out_ready=1 -> Rb 5,6,7 on consecutive cycles, last on 7, done_o next cycle.
REQ-036 req_rb=0x41, cnt=2, down -> field 0x01 regx=1, then field 0x00 regx=1; template bits outside [24:19] unchanged.
REQ-037 req_rb=127, cnt=2, up -> Rb 127 then 0 (regx 1 then 0).
REQ-038 out_ready held 0 for 4 cycles mid-sequence -> outputs stable, no Rb skipped.
REQ-039 flush_i asserted after first output of cnt=4 -> out_valid 0 next cycle, no done_o, req_ready 1.
REQ-040 With SKIP_R0_EN: req_rb=126, cnt=3, up -> Rb 126,127,1; without it -> 126,127,0.

Source files
------------

// File: rtl/qupls_rb_encode_seq_pkg.sv
// QuplsPkg: shared types and constants for the Rb-field encode sequencer.
//   instruction_t : instruction word carried through the sequencer
//   aregno_t      : architectural register number; bit 6 is the extension bit
//   RB_LSB/RB_MSB : position of the 6-bit Rb field inside instruction_t
//   seq_state_e   : sequencer FSM states
package QuplsPkg;

    typedef logic [39:0] instruction_t;
    typedef logic [6:0]  aregno_t;

    localparam int unsigned RB_LSB = 19;
    localparam int unsigned RB_MSB = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/qupls_encode_rb_field.sv
// qupls_encode_rb_field: combinational Rb field insertion, the inverse of the
// Rb field decode. The low six register bits land in [RB_MSB:RB_LSB]; bit 6
// travels separately as the register-extension flag.
//   instr_i : template instruction
//   rb_i    : register number to insert
//   instr_o : template with the Rb field replaced
//   regx_o  : bit 6 of rb_i
module qupls_encode_rb_field
    import QuplsPkg::*;
(
    input  instruction_t instr_i,
    input  aregno_t      rb_i,
    output instruction_t instr_o,
    output logic         regx_o
);

    always_comb begin
        instr_o                = instr_i;
        instr_o[RB_MSB:RB_LSB] = rb_i[5:0];
        regx_o                 = rb_i[6];
    end

endmodule

// File: rtl/qupls_rb_encode_seq.sv
// qupls_rb_encode_seq: expands one request into a sequence of instructions,
// each a copy of the template with the Rb field set to a stepping register
// number (incrementing or decrementing, modulo 128).
//   clk_i, rst_i        : clock, synchronous active-high reset
//   flush_i             : abort the current sequence, no done pulse
//   req_valid_i/ready_o : request handshake (template, first Rb, count, dir)
//   out_valid_o/ready_i : output handshake (instr, regx, last)
//   done_o              : one-cycle pulse after the final output handshake
// Optional build macro QUPLS_RB_SEQ_SKIP_R0_EN: register 0 is skipped with a
// bubble cycle and does not consume count.
module qupls_rb_encode_seq
    import QuplsPkg::*;
#(
    parameter int unsigned MAXCNT = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  instruction_t                 req_instr_i,
    input  aregno_t                      req_rb_i,
    input  logic [$clog2(MAXCNT+1)-1:0]  req_cnt_i,
    input  logic                         req_down_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output instruction_t                 out_instr_o,
    output logic                         out_regx_o,
    output logic                         out_last_o,
    output logic                         done_o
);

    localparam int unsigned CW = $clog2(MAXCNT + 1);

    seq_state_e   state, state_nxt;
    instruction_t tmpl, tmpl_nxt;
    aregno_t      cur_rb, rb_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic         down, down_nxt;
    logic         skip_r0;
    aregno_t      rb_step;

`ifdef QUPLS_RB_SEQ_SKIP_R0_EN
    assign skip_r0 = (cur_rb == '0);
`else
    assign skip_r0 = 1'b0;
`endif

    // 7-bit arithmetic wraps 127->0 and 0->127 on its own.
    assign rb_step = down ? cur_rb - 7'd1 : cur_rb + 7'd1;

    qupls_encode_rb_field u_enc (
        .instr_i (tmpl),
        .rb_i    (cur_rb),
        .instr_o (out_instr_o),
        .regx_o  (out_regx_o)
    );

    assign req_ready_o = (state == IDLE) && !rst_i;
    assign out_valid_o = (state == EMIT) && !skip_r0;
    assign out_last_o  = out_valid_o && (cnt == CW'(1));
    assign done_o      = (state == DONE);

    always_comb begin
        state_nxt = state;
        tmpl_nxt  = tmpl;
        rb_nxt    = cur_rb;
        cnt_nxt   = cnt;
        down_nxt  = down;
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    if (req_cnt_i == '0) begin
                        state_nxt = DONE;
                    end else begin
                        tmpl_nxt  = req_instr_i;
                        rb_nxt    = req_rb_i;
                        down_nxt  = req_down_i;
                        cnt_nxt   = (req_cnt_i > CW'(MAXCNT)) ? CW'(MAXCNT) : req_cnt_i;
                        state_nxt = EMIT;
                    end
                end
            end
            EMIT: begin
                if (skip_r0) begin
                    // Bubble: advance past register 0 without touching count.
                    rb_nxt = rb_step;
                end else if (out_ready_i) begin
                    rb_nxt  = rb_step;
                    cnt_nxt = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Flush overrides everything, including a same-cycle request.
        if (flush_i) begin
            state_nxt = IDLE;
            tmpl_nxt  = tmpl;
            rb_nxt    = cur_rb;
            down_nxt  = down;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            tmpl   <= '0;
            cur_rb <= '0;
            cnt    <= '0;
            down   <= 1'b0;
        end else begin
            state  <= state_nxt;
            tmpl   <= tmpl_nxt;
            cur_rb <= rb_nxt;
            cnt    <= cnt_nxt;
            down   <= down_nxt;
        end
    end

endmodule

// File: tb/tb_qupls_rb_encode_seq.sv
module tb_qupls_rb_encode_seq;
    import QuplsPkg::*;

    localparam int unsigned MAXCNT = 8;
    localparam int unsigned CW = $clog2(MAXCNT + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    instruction_t  req_instr = '0;
    aregno_t       req_rb = '0;
    logic [CW-1:0] req_cnt = '0;
    logic          req_down = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    instruction_t  out_instr;
    logic          out_regx;
    logic          out_last;
    logic          done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    qupls_rb_encode_seq #(.MAXCNT(MAXCNT)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_instr_i (req_instr),
        .req_rb_i    (req_rb),
        .req_cnt_i   (req_cnt),
        .req_down_i  (req_down),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_instr_o (out_instr),
        .out_regx_o  (out_regx),
        .out_last_o  (out_last),
        .done_o      (done)
    );

    localparam instruction_t TMPL = 40'hA5_5A5A_5A5A;
    localparam instruction_t RBMASK = 40'h00_01F8_0000;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check one emitted output: valid, Rb field, regx, untouched template bits, last.
    task automatic chk_out(input string tag, input int rb, input logic last);
        logic [6:0] r;
        instruction_t e;
        r = 7'(rb);
        e = (TMPL & ~RBMASK) | (instruction_t'(r[5:0]) << 19);
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".instr"}, 64'(out_instr), 64'(e));
        chk({tag, ".regx"}, 64'(out_regx), 64'(r[6]));
        chk({tag, ".last"}, 64'(out_last), 64'(last));
    endtask

    task automatic request(input int rb, input int cnt, input logic dn);
        req_valid = 1'b1;
        req_instr = TMPL;
        req_rb    = 7'(rb);
        req_cnt   = CW'(cnt);
        req_down  = dn;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        int n;
        // Reset
        #1;
        chk("rst.ready_during", 64'(req_ready), 64'd0);
        step();
        chk("rst.ready_during2", 64'(req_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst.ready", 64'(req_ready), 64'd1);
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.last", 64'(out_last), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.regx", 64'(out_regx), 64'd0);
        chk("rst.instr", 64'(out_instr), 64'd0);

        // Rb 5,6,7 up
        request(5, 3, 1'b0);
        chk("t1.ready_busy", 64'(req_ready), 64'd0);
        chk_out("t1.r5", 5, 1'b0);
        step();
        chk_out("t1.r6", 6, 1'b0);
        step();
        chk_out("t1.r7", 7, 1'b1);
        step();
        chk("t1.done", 64'(done), 64'd1);
        chk("t1.valid_off", 64'(out_valid), 64'd0);
        chk("t1.ready_done", 64'(req_ready), 64'd0);
        step();
        chk("t1.done_off", 64'(done), 64'd0);
        chk("t1.ready_back", 64'(req_ready), 64'd1);

        // 0x41 down
        request(65, 2, 1'b1);
        chk_out("t2.r41", 65, 1'b0);
        step();
        chk_out("t2.r40", 64, 1'b1);
        step();
        chk("t2.done", 64'(done), 64'd1);
        step();

        // 127 up wraps to 0
        request(127, 2, 1'b0);
        chk_out("t3.r127", 127, 1'b0);
        step();
`ifdef QUPLS_RB_SEQ_SKIP_R0_EN
        chk("t3.bubble", 64'(out_valid), 64'd0);
        step();
        chk_out("t3.r1", 1, 1'b1);
`else
        chk_out("t3.r0", 0, 1'b1);
`endif
        step();
        chk("t3.done", 64'(done), 64'd1);
        step();

        // Back-pressure: 4 stalled cycles
        request(10, 3, 1'b0);
        chk_out("t4.r10", 10, 1'b0);
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_out("t4.stall", 11, 1'b0);
            step();
        end
        out_ready = 1'b1;
        chk_out("t4.r11", 11, 1'b0);
        step();
        chk_out("t4.r12", 12, 1'b1);
        step();
        chk("t4.done", 64'(done), 64'd1);
        step();

        // Flush after first output
        request(20, 4, 1'b0);
        chk_out("t5.r20", 20, 1'b0);
        step();
        chk_out("t5.r21", 21, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t5.valid", 64'(out_valid), 64'd0);
        chk("t5.done", 64'(done), 64'd0);
        chk("t5.ready", 64'(req_ready), 64'd1);
        step();
        chk("t5.done2", 64'(done), 64'd0);
        chk("t5.valid2", 64'(out_valid), 64'd0);

        // Flush coincident with request discards it
        flush = 1'b1;
        request(40, 2, 1'b0);
        flush = 1'b0;
        chk("t6.valid", 64'(out_valid), 64'd0);
        chk("t6.ready", 64'(req_ready), 64'd1);
        step();
        chk("t6.done", 64'(done), 64'd0);

        // Zero count: straight to DONE
        request(3, 0, 1'b0);
        chk("t7.valid", 64'(out_valid), 64'd0);
        chk("t7.done", 64'(done), 64'd1);
        step();
        chk("t7.ready", 64'(req_ready), 64'd1);

        // Clamp 15 -> MAXCNT
        request(30, 15, 1'b0);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) break;
            if (out_valid) begin
                chk("t8.rb", 64'(out_instr[24:19]), 64'(30 + n));
                chk("t8.last", 64'(out_last), 64'(n == int'(MAXCNT) - 1));
                n++;
            end
            step();
        end
        chk("t8.count", 64'(n), 64'(MAXCNT));
        chk("t8.done", 64'(done), 64'd1);
        step();

        // 126 up across register 0
        request(126, 3, 1'b0);
        chk_out("t9.r126", 126, 1'b0);
        step();
        chk_out("t9.r127", 127, 1'b0);
        step();
`ifdef QUPLS_RB_SEQ_SKIP_R0_EN
        chk("t9.bubble", 64'(out_valid), 64'd0);
        step();
        chk_out("t9.r1", 1, 1'b1);
`else
        chk_out("t9.r0", 0, 1'b1);
`endif
        step();
        chk("t9.done", 64'(done), 64'd1);
        step();

        // Reset mid-sequence
        request(50, 4, 1'b0);
        chk_out("t10.r50", 50, 1'b0);
        rst = 1'b1;
        #1;
        chk("t10.ready_rst", 64'(req_ready), 64'd0);
        step();
        rst = 1'b0;
        #1;
        chk("t10.valid", 64'(out_valid), 64'd0);
        chk("t10.done", 64'(done), 64'd0);
        chk("t10.ready", 64'(req_ready), 64'd1);
        chk("t10.instr", 64'(out_instr), 64'd0);
        step();
        chk("t10.done2", 64'(done), 64'd0);
        chk("t10.valid2", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
